// File: rtl/spi_master.sv
// spi_master -- SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first.
//
// Accepts a parallel word on a start strobe, drives sclk / csN / mosi and
// captures miso into a parallel word. Signals completion with a one-cycle
// done pulse. Every non-idle phase lasts CLKDIV clk cycles.
//
// Ports:
//   clk     in   system clock, rising-edge active
//   resetN  in   asynchronous active-low reset
//   start   in   transaction request, sampled only while idle
//   txData  in   word to send, latched when start is accepted
//   busy    out  high while a transaction is in flight
//   done    out  one-cycle pulse at end of transaction
//   rxData  out  last received word, updated with done
//   sclk    out  serial clock, idles low
//   csN     out  chip select, active low
//   mosi    out  serial data out
//   miso    in   serial data in
module spi_master #(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [WIDTH-1:0] txData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rxData,
  output logic             sclk,
  output logic             csN,
  output logic             mosi,
  input  logic             miso
);

  localparam int DIVW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BITW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} stateType;

  stateType         state, stateNext;
  logic [DIVW-1:0]  divCnt, divCntNext;
  logic [BITW-1:0]  bitCnt, bitCntNext;
  logic [WIDTH-1:0] txShift, txShiftNext;
  logic [WIDTH-1:0] rxShift, rxShiftNext;
  logic [WIDTH-1:0] rxDataNext;
  logic             busyNext, doneNext, sclkNext, csNNext, mosiNext;
  logic             phaseEnd;

  assign phaseEnd = (divCnt == DIVW'(CLKDIV - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      divCnt  <= '0;
      bitCnt  <= '0;
      txShift <= '0;
      rxShift <= '0;
      rxData  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      csN     <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      state   <= stateNext;
      divCnt  <= divCntNext;
      bitCnt  <= bitCntNext;
      txShift <= txShiftNext;
      rxShift <= rxShiftNext;
      rxData  <= rxDataNext;
      busy    <= busyNext;
      done    <= doneNext;
      sclk    <= sclkNext;
      csN     <= csNNext;
      mosi    <= mosiNext;
    end
  end

  always_comb begin
    stateNext   = state;
    divCntNext  = divCnt;
    bitCntNext  = bitCnt;
    txShiftNext = txShift;
    rxShiftNext = rxShift;
    rxDataNext  = rxData;
    busyNext    = busy;
    doneNext    = 1'b0;   // done is a single-cycle pulse
    sclkNext    = sclk;
    csNNext     = csN;
    mosiNext    = mosi;

    // Phase timer runs in every non-idle state and wraps at phase end.
    if (state != IDLE) begin
      divCntNext = phaseEnd ? '0 : divCnt + DIVW'(1);
    end

    case (state)
      IDLE: begin
        divCntNext = '0;
        if (start) begin
          txShiftNext = txData;
          mosiNext    = txData[WIDTH-1];
          csNNext     = 1'b0;
          busyNext    = 1'b1;
          bitCntNext  = '0;
          stateNext   = SETUP;
        end
      end
      SETUP, LOW: begin
        if (phaseEnd) begin
          stateNext = HIGH;
          sclkNext  = 1'b1;
        end
      end
      HIGH: begin
        if (phaseEnd) begin
          // Sample miso on the last edge of the high phase, just as sclk falls.
          rxShiftNext = {rxShift[WIDTH-2:0], miso};
          sclkNext    = 1'b0;
          if (bitCnt == BITW'(WIDTH - 1)) begin
            stateNext = HOLD;
          end else begin
            // mosi only moves together with sclk falling.
            stateNext   = LOW;
            txShiftNext = {txShift[WIDTH-2:0], 1'b0};
            mosiNext    = txShift[WIDTH-2];
            bitCntNext  = bitCnt + BITW'(1);
          end
        end
      end
      HOLD: begin
        if (phaseEnd) begin
          stateNext  = IDLE;
          csNNext    = 1'b1;
          busyNext   = 1'b0;
          mosiNext   = 1'b0;
          doneNext   = 1'b1;
          rxDataNext = rxShift;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master -- directed self-checking bench for spi_master.
// dut0: WIDTH=8, CLKDIV=2, miso from loopback or a small slave model.
// dut1: WIDTH=8, CLKDIV=1, miso looped back from mosi.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;

  logic       start0 = 1'b0;
  logic [7:0] txData0 = 8'h00;
  logic       busy0, done0, sclk0, csN0, mosi0, miso0;
  logic [7:0] rxData0;

  logic       start1 = 1'b0;
  logic [7:0] txData1 = 8'h00;
  logic       busy1, done1, sclk1, csN1, mosi1, miso1;
  logic [7:0] rxData1;

  logic       loopback = 1'b1;
  logic [7:0] slaveWord = 8'h00;
  logic [7:0] slaveSh = 8'h00;
  logic [7:0] slaveRx = 8'h00;
  logic       csNPrev = 1'b1;
  logic       slaveMiso;

  int         assertCnt = 0;
  int         failCnt = 0;

  int         low0 = 0, doneCnt0 = 0, rise0 = 0;
  int         low1 = 0, doneCnt1 = 0, rise1 = 0;
  logic [31:0] mosiHist = 32'h0;
  time        lastRise1 = 0, risePeriod1 = 0;

  always #5 clk = ~clk;

  assign slaveMiso = slaveSh[7];
  assign miso0     = loopback ? mosi0 : slaveMiso;
  assign miso1     = mosi1;

  spi_master #(.WIDTH(8), .CLKDIV(2)) dut0 (
    .clk(clk), .resetN(resetN), .start(start0), .txData(txData0),
    .busy(busy0), .done(done0), .rxData(rxData0), .sclk(sclk0),
    .csN(csN0), .mosi(mosi0), .miso(miso0)
  );

  spi_master #(.WIDTH(8), .CLKDIV(1)) dut1 (
    .clk(clk), .resetN(resetN), .start(start1), .txData(txData1),
    .busy(busy1), .done(done1), .rxData(rxData1), .sclk(sclk1),
    .csN(csN1), .mosi(mosi1), .miso(miso1)
  );

  // Slave model: presents MSB when csN falls, advances on sclk falling.
  always @(negedge csN0 or posedge csN0 or negedge sclk0) begin
    if (csN0 != csNPrev) begin
      if (!csN0) slaveSh = slaveWord;
      csNPrev = csN0;
    end else if (!sclk0) begin
      slaveSh = {slaveSh[6:0], 1'b0};
    end
  end

  always @(posedge sclk0) begin
    slaveRx  = {slaveRx[6:0], mosi0};
    mosiHist = {mosiHist[30:0], mosi0};
    rise0++;
  end

  always @(posedge sclk1) begin
    rise1++;
    risePeriod1 = $time - lastRise1;
    lastRise1   = $time;
  end

  // Cycle monitors, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (!csN0) low0++;
    if (done0) doneCnt0++;
    if (!csN1) low1++;
    if (done1) doneCnt1++;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    assertCnt++;
    if (observed !== expected) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%0h", tag, observed);
    end
  endtask

  // Returns at the negedge where done0 is high, or after a cycle budget.
  task automatic waitDone0(input string tag);
    int n = 0;
    while (!done0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done0, 1);
  endtask

  task automatic pulseStart0(input logic [7:0] word);
    txData0 = word;
    start0  = 1'b1;
    @(negedge clk);
    start0  = 1'b0;
  endtask

  initial begin
    int sLow, sDone, sRise, n;

    // Reset state
    #12;
    check("rst_csN", csN0, 1);
    check("rst_sclk", sclk0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_rx", rxData0, 0);
    check("rst_mosi", mosi0, 0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    // Loopback 0xA5
    loopback = 1'b1;
    sLow = low0; sDone = doneCnt0; sRise = rise0;
    pulseStart0(8'hA5);
    check("lb_busy", busy0, 1);
    waitDone0("lb");
    check("lb_rx", rxData0, 8'hA5);
    @(negedge clk);
    check("lb_busy_after", busy0, 0);
    check("lb_rises", rise0 - sRise, 8);
    check("lb_csN_low", low0 - sLow, 34);
    check("lb_done_cnt", doneCnt0 - sDone, 1);

    // Slave model presents 0x3C, master sends 0x92
    loopback  = 1'b0;
    slaveWord = 8'h3C;
    pulseStart0(8'h92);
    waitDone0("slv");
    check("slv_rx", rxData0, 8'h3C);
    check("slv_capture", slaveRx, 8'h92);
    @(negedge clk);
    loopback = 1'b1;

    // Back-to-back with start held high
    sLow = low0; sDone = doneCnt0;
    txData0 = 8'h01;
    start0  = 1'b1;
    @(negedge clk);
    txData0 = 8'hFF;
    waitDone0("b2b1");
    check("b2b1_rx", rxData0, 8'h01);
    check("b2b_gap_csN", csN0, 1);
    @(negedge clk);
    check("b2b_restart_csN", csN0, 0);
    start0 = 1'b0;
    waitDone0("b2b2");
    check("b2b2_rx", rxData0, 8'hFF);
    repeat (40) @(negedge clk);
    check("b2b_done_cnt", doneCnt0 - sDone, 2);
    check("b2b_csN_low", low0 - sLow, 68);

    // Start ignored while busy
    sDone = doneCnt0; sRise = rise0;
    pulseStart0(8'h0F);
    repeat (10) @(negedge clk);
    pulseStart0(8'h55);
    waitDone0("ign");
    check("ign_rx", rxData0, 8'h0F);
    check("ign_mosi_seq", mosiHist[7:0], 8'h0F);
    repeat (40) @(negedge clk);
    check("ign_done_cnt", doneCnt0 - sDone, 1);
    check("ign_rises", rise0 - sRise, 8);
    check("ign_idle_csN", csN0, 1);

    // Asynchronous reset after the 3rd sclk rising edge
    sRise = rise0;
    pulseStart0(8'hAA);
    n = 0;
    while ((rise0 - sRise) < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst3_rises", rise0 - sRise, 3);
    sDone = doneCnt0;
    #2 resetN = 1'b0;
    #1;
    check("arst_csN", csN0, 1);
    check("arst_sclk", sclk0, 0);
    check("arst_busy", busy0, 0);
    check("arst_rx", rxData0, 0);
    @(negedge clk);
    #2 resetN = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_no_done", doneCnt0 - sDone, 0);
    check("arst_idle_csN", csN0, 1);
    pulseStart0(8'hC3);
    waitDone0("post_rst");
    check("post_rst_rx", rxData0, 8'hC3);
    @(negedge clk);

    // CLKDIV=1 instance, loopback 0x7E
    sLow = low1; sRise = rise1;
    txData1 = 8'h7E;
    start1  = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("div1_done", done1, 1);
    check("div1_rx", rxData1, 8'h7E);
    @(negedge clk);
    check("div1_csN_low", low1 - sLow, 17);
    check("div1_rises", rise1 - sRise, 8);
    check("div1_sclk_period", 32'(risePeriod1), 20);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
